// File: rtl/tick_period_monitor.sv
// Receive-side checker for a periodic one-cycle enable tick: measures tick spacing,
// declares lock after a run of in-tolerance periods, flags period errors and tick loss.
module tick_period_monitor #(
    parameter int EXPECTED   = 100,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int MAX_PERIOD = 1024,
    localparam int W         = $clog2(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         err,
    output logic         timeout,
    output logic [7:0]   err_count
);
    localparam int MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t        state, state_d;
    logic [W-1:0]  cnt, cnt_d;
    logic [MW-1:0] match_cnt, match_d;
    logic [W-1:0]  period_d;
    logic          pv_d, err_d, to_d, locked_d;
    logic [7:0]    errc_d;

    logic [W-1:0]        meas;
    logic signed [W:0]   diff;
    logic [W:0]          mag;
    logic                in_tol;
    logic                cnt_expired;

    // Deviation is formed one bit wider than the period so it can never wrap.
    always_comb begin
        meas        = cnt + W'(1);
        diff        = $signed({1'b0, meas}) - $signed((W+1)'(EXPECTED));
        mag         = diff[W] ? unsigned'(-diff) : unsigned'(diff);
        in_tol      = (mag <= (W+1)'(TOL));
        cnt_expired = (cnt == W'(MAX_PERIOD - 1));
    end

    always_comb begin
        state_d  = state;
        cnt_d    = (state == IDLE) ? '0 : cnt + W'(1);
        match_d  = match_cnt;
        period_d = period;
        pv_d     = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        errc_d   = err_count;
        case (state)
            IDLE: begin
                if (en_in) begin
                    state_d = ACQUIRE;
                    match_d = '0;
                end
            end
            ACQUIRE: begin
                if (en_in) begin
                    cnt_d    = '0;
                    period_d = meas;
                    pv_d     = 1'b1;
                    if (!in_tol) begin
                        match_d = '0;
                    end else if (match_cnt + MW'(1) == MW'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        match_d = '0;
                    end else begin
                        match_d = match_cnt + MW'(1);
                    end
                end else if (cnt_expired) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    match_d = '0;
                end
            end
            LOCKED: begin
                if (en_in) begin
                    cnt_d    = '0;
                    period_d = meas;
                    pv_d     = 1'b1;
                    if (!in_tol) begin
                        err_d   = 1'b1;
                        errc_d  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                        state_d = ACQUIRE;
                        match_d = '0;
                    end
                end else if (cnt_expired) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    match_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                match_d = '0;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            match_cnt    <= match_d;
            period       <= period_d;
            period_valid <= pv_d;
            locked       <= locked_d;
            err          <= err_d;
            timeout      <= to_d;
            err_count    <= errc_d;
        end
    end
endmodule
